// File: rtl/exec_unit_if.sv
// ---------------------------------------------------------------------------
// Module   : exec_unit_if
// Purpose  : Operand, control and result bundle between the decode/forwarding
//            muxes and the execute-stage arithmetic core.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface exec_unit_if;
   logic [4:0]  Op;
   logic [3:0]  MemOp;
   logic [2:0]  XOp;
   logic [31:0] A;
   logic [31:0] B;
   logic [4:0]  Shamt;
   logic [15:0] Imm16;
   logic [31:0] PC;
   logic        Flush;
   logic [31:0] C;
   logic        OverFlow;
   logic        LoadEn;
   logic [3:0]  ByteEn;
   logic [31:0] StoreData;
   logic        LoadAlignErr;
   logic        StoreAlignErr;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;

   // Pipeline side: drives operands/controls, observes results
   modport master (
      output Op, MemOp, XOp, A, B, Shamt, Imm16, PC, Flush,
      input  C, OverFlow, LoadEn, ByteEn, StoreData, LoadAlignErr,
             StoreAlignErr, HI, LO, Busy
   );

   // Execute core side
   modport slave (
      input  Op, MemOp, XOp, A, B, Shamt, Imm16, PC, Flush,
      output C, OverFlow, LoadEn, ByteEn, StoreData, LoadAlignErr,
             StoreAlignErr, HI, LO, Busy
   );
endinterface

`default_nettype wire

// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// Module   : exec_unit
// Purpose  : MIPS execute-stage core: combinational ALU with signed overflow,
//            combinational load/store control, and a multi-cycle
//            multiply/divide unit with HI/LO registers.
//            The multiply/divide unit is only built when EXEC_MULDIV_EN is
//            defined; otherwise HI/LO/Busy are constant zero and XOp is
//            ignored.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module exec_unit #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input logic        Clk,
   input logic        Clr,
   exec_unit_if.slave bus
);

   localparam logic [4:0] c_OP_ADD   = 5'd1;
   localparam logic [4:0] c_OP_ADDU  = 5'd2;
   localparam logic [4:0] c_OP_SUB   = 5'd3;
   localparam logic [4:0] c_OP_SUBU  = 5'd4;
   localparam logic [4:0] c_OP_AND   = 5'd5;
   localparam logic [4:0] c_OP_OR    = 5'd6;
   localparam logic [4:0] c_OP_XOR   = 5'd7;
   localparam logic [4:0] c_OP_NOR   = 5'd8;
   localparam logic [4:0] c_OP_SLT   = 5'd9;
   localparam logic [4:0] c_OP_SLTU  = 5'd10;
   localparam logic [4:0] c_OP_SLL   = 5'd11;
   localparam logic [4:0] c_OP_SRL   = 5'd12;
   localparam logic [4:0] c_OP_SRA   = 5'd13;
   localparam logic [4:0] c_OP_SLLV  = 5'd14;
   localparam logic [4:0] c_OP_SRLV  = 5'd15;
   localparam logic [4:0] c_OP_SRAV  = 5'd16;
   localparam logic [4:0] c_OP_ADDI  = 5'd17;
   localparam logic [4:0] c_OP_ADDIU = 5'd18;
   localparam logic [4:0] c_OP_ANDI  = 5'd19;
   localparam logic [4:0] c_OP_ORI   = 5'd20;
   localparam logic [4:0] c_OP_XORI  = 5'd21;
   localparam logic [4:0] c_OP_LUI   = 5'd22;
   localparam logic [4:0] c_OP_SLTI  = 5'd23;
   localparam logic [4:0] c_OP_SLTIU = 5'd24;
   localparam logic [4:0] c_OP_LINK  = 5'd25;
   localparam logic [4:0] c_OP_MFHI  = 5'd26;
   localparam logic [4:0] c_OP_MFLO  = 5'd27;

   localparam logic [3:0] c_MEM_LB  = 4'd1;
   localparam logic [3:0] c_MEM_LBU = 4'd2;
   localparam logic [3:0] c_MEM_LH  = 4'd3;
   localparam logic [3:0] c_MEM_LHU = 4'd4;
   localparam logic [3:0] c_MEM_LW  = 4'd5;
   localparam logic [3:0] c_MEM_SB  = 4'd6;
   localparam logic [3:0] c_MEM_SH  = 4'd7;
   localparam logic [3:0] c_MEM_SW  = 4'd8;

   logic [31:0] w_sext;
   logic [31:0] w_zext;
   logic [31:0] w_alu;
   logic [32:0] w_ovf_sum;
   logic [31:0] w_ea;
   logic        w_mem_act;
   logic [1:0]  w_addr;
   logic        w_load_en;
   logic        w_lerr;
   logic        w_serr;
   logic [3:0]  w_be;
   logic [31:0] w_sd;
   logic [31:0] w_hi;
   logic [31:0] w_lo;

   assign w_sext = {{16{bus.Imm16[15]}}, bus.Imm16};
   assign w_zext = {16'h0000, bus.Imm16};

   // ALU result selection by operation code
   always_comb begin
      w_alu = '0;
      case (bus.Op)
         c_OP_ADD, c_OP_ADDU:   w_alu = bus.A + bus.B;
         c_OP_SUB, c_OP_SUBU:   w_alu = bus.A - bus.B;
         c_OP_AND:              w_alu = bus.A & bus.B;
         c_OP_OR:               w_alu = bus.A | bus.B;
         c_OP_XOR:              w_alu = bus.A ^ bus.B;
         c_OP_NOR:              w_alu = ~(bus.A | bus.B);
         c_OP_SLT:              w_alu = {31'd0, $signed(bus.A) < $signed(bus.B)};
         c_OP_SLTU:             w_alu = {31'd0, bus.A < bus.B};
         c_OP_SLL:              w_alu = bus.B << bus.Shamt;
         c_OP_SRL:              w_alu = bus.B >> bus.Shamt;
         c_OP_SRA:              w_alu = $unsigned($signed(bus.B) >>> bus.Shamt);
         c_OP_SLLV:             w_alu = bus.B << bus.A[4:0];
         c_OP_SRLV:             w_alu = bus.B >> bus.A[4:0];
         c_OP_SRAV:             w_alu = $unsigned($signed(bus.B) >>> bus.A[4:0]);
         c_OP_ADDI, c_OP_ADDIU: w_alu = bus.A + w_sext;
         c_OP_ANDI:             w_alu = bus.A & w_zext;
         c_OP_ORI:              w_alu = bus.A | w_zext;
         c_OP_XORI:             w_alu = bus.A ^ w_zext;
         c_OP_LUI:              w_alu = {bus.Imm16, 16'h0000};
         c_OP_SLTI:             w_alu = {31'd0, $signed(bus.A) < $signed(w_sext)};
         c_OP_SLTIU:            w_alu = {31'd0, bus.A < w_sext};
         c_OP_LINK:             w_alu = bus.PC + 32'd8;
         c_OP_MFHI:             w_alu = w_hi;
         c_OP_MFLO:             w_alu = w_lo;
         default:               w_alu = '0;
      endcase
   end

   // 33-bit sign-extended sum for the trapping adds; overflow when the two top bits differ
   always_comb begin
      w_ovf_sum = '0;
      case (bus.Op)
         c_OP_ADD:  w_ovf_sum = {bus.A[31], bus.A} + {bus.B[31], bus.B};
         c_OP_SUB:  w_ovf_sum = {bus.A[31], bus.A} - {bus.B[31], bus.B};
         c_OP_ADDI: w_ovf_sum = {bus.A[31], bus.A} + {w_sext[31], w_sext};
         default:   w_ovf_sum = '0;
      endcase
   end

   assign bus.OverFlow = w_ovf_sum[32] ^ w_ovf_sum[31];

   // Memory ops replace the ALU result with the effective address
   assign w_mem_act = (bus.MemOp >= c_MEM_LB) && (bus.MemOp <= c_MEM_SW);
   assign w_ea      = bus.A + w_sext;
   assign bus.C     = w_mem_act ? w_ea : w_alu;
   assign w_addr    = w_ea[1:0];

   // Load enable, alignment checks, byte lanes and lane-replicated store data
   always_comb begin
      w_load_en = 1'b0;
      w_lerr    = 1'b0;
      w_serr    = 1'b0;
      w_be      = 4'b0000;
      w_sd      = bus.B;
      case (bus.MemOp)
         c_MEM_LB, c_MEM_LBU: w_load_en = 1'b1;
         c_MEM_LH, c_MEM_LHU: begin
            w_load_en = 1'b1;
            w_lerr    = w_addr[0];
         end
         c_MEM_LW: begin
            w_load_en = 1'b1;
            w_lerr    = |w_addr;
         end
         c_MEM_SB: begin
            w_be = 4'b0001 << w_addr;
            w_sd = {4{bus.B[7:0]}};
         end
         c_MEM_SH: begin
            w_serr = w_addr[0];
            w_be   = w_addr[0] ? 4'b0000 : (w_addr[1] ? 4'b1100 : 4'b0011);
            w_sd   = {2{bus.B[15:0]}};
         end
         c_MEM_SW: begin
            w_serr = |w_addr;
            w_be   = (|w_addr) ? 4'b0000 : 4'b1111;
         end
         default: w_load_en = 1'b0;
      endcase
   end

   assign bus.LoadEn        = w_load_en;
   assign bus.LoadAlignErr  = w_lerr;
   assign bus.StoreAlignErr = w_serr;
   assign bus.ByteEn        = w_be;
   assign bus.StoreData     = w_sd;

`ifdef EXEC_MULDIV_EN
   localparam int c_MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int c_CW         = $clog2(c_MAX_CYCLES) + 1;

   localparam logic [2:0] c_X_MULT  = 3'd1;
   localparam logic [2:0] c_X_MULTU = 3'd2;
   localparam logic [2:0] c_X_DIV   = 3'd3;
   localparam logic [2:0] c_X_DIVU  = 3'd4;
   localparam logic [2:0] c_X_MTHI  = 3'd5;
   localparam logic [2:0] c_X_MTLO  = 3'd6;

   logic            r_busy;
   logic [c_CW-1:0] r_cnt;
   logic [2:0]      r_xop;
   logic [31:0]     r_a;
   logic [31:0]     r_b;
   logic [31:0]     r_hi;
   logic [31:0]     r_lo;

   logic            w_start;
   logic            w_is_mul;
   logic            w_sdiv;
   logic [63:0]     w_prod;
   logic [31:0]     w_mag_a;
   logic [31:0]     w_mag_b;
   logic [31:0]     w_quo;
   logic [31:0]     w_rem;
   logic [31:0]     w_res_hi;
   logic [31:0]     w_res_lo;

   assign w_start  = (bus.XOp >= c_X_MULT) && (bus.XOp <= c_X_DIVU);
   assign w_is_mul = (bus.XOp == c_X_MULT) || (bus.XOp == c_X_MULTU);
   assign w_sdiv   = (r_xop == c_X_DIV);

   // Signed divide works on magnitudes; divisor forced non-zero since zero is special-cased
   assign w_mag_a = (w_sdiv && r_a[31]) ? (32'd0 - r_a) : r_a;
   assign w_mag_b = (r_b == 32'd0) ? 32'd1 :
                    ((w_sdiv && r_b[31]) ? (32'd0 - r_b) : r_b);
   assign w_quo   = w_mag_a / w_mag_b;
   assign w_rem   = w_mag_a % w_mag_b;

   // Result from the latched operands, captured into HI/LO when Busy falls
   always_comb begin
      w_prod   = '0;
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (r_xop)
         c_X_MULT: begin
            w_prod   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
         end
         c_X_MULTU: begin
            w_prod   = {32'd0, r_a} * {32'd0, r_b};
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
         end
         c_X_DIV, c_X_DIVU: begin
            if (r_b == 32'd0) begin
               w_res_lo = 32'hFFFF_FFFF;
               w_res_hi = r_a;
            end else if (w_sdiv) begin
               w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_quo) : w_quo;
               w_res_hi = r_a[31] ? (32'd0 - w_rem) : w_rem;
            end else begin
               w_res_lo = w_quo;
               w_res_hi = w_rem;
            end
         end
         default: w_prod = '0;
      endcase
   end

   // Accept, count down, deliver result; Flush abandons the op without touching HI/LO
   always_ff @(posedge Clk) begin
      if (!Clr) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_xop  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else if (bus.Flush) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (r_busy) begin
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else if (w_start) begin
         r_busy <= 1'b1;
         r_xop  <= bus.XOp;
         r_a    <= bus.A;
         r_b    <= bus.B;
         r_cnt  <= w_is_mul ? c_CW'(MUL_CYCLES - 1) : c_CW'(DIV_CYCLES - 1);
      end else if (bus.XOp == c_X_MTHI) begin
         r_hi <= bus.A;
      end else if (bus.XOp == c_X_MTLO) begin
         r_lo <= bus.A;
      end
   end

   assign w_hi     = r_hi;
   assign w_lo     = r_lo;
   assign bus.Busy = r_busy;
`else
   logic w_unused;

   assign w_unused = ^{Clk, Clr, bus.XOp, bus.Flush};
   assign w_hi     = '0;
   assign w_lo     = '0;
   assign bus.Busy = 1'b0;
`endif

   assign bus.HI = w_hi;
   assign bus.LO = w_lo;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ---------------------------------------------------------------------------
// Module   : tb_exec_unit
// Purpose  : Self-checking bench for exec_unit: directed corner cases plus
//            randomized ALU / memory-control / multiply-divide traffic
//            compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exec_unit;

   localparam int MUL_N = 4;
   localparam int DIV_N = 32;
`ifdef EXEC_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Clr;
   always #5 Clk = ~Clk;

   exec_unit_if bus();

   exec_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [15:0] imm);
      return imm[15] ? {16'hFFFF, imm} : {16'h0000, imm};
   endfunction

   function automatic logic [31:0] sra_f(input logic [31:0] v, input logic [4:0] s);
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      return (v >> s) | (v[31] ? ~(ones >> s) : 32'h0);
   endfunction

   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic [15:0] imm, input logic [31:0] pc);
      logic [31:0] se;
      se = sext(imm);
      case (op)
         1, 2:   return a + b;
         3, 4:   return a - b;
         5:      return a & b;
         6:      return a | b;
         7:      return a ^ b;
         8:      return ~(a | b);
         9:      return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         10:     return (a < b) ? 32'd1 : 32'd0;
         11:     return b << sh;
         12:     return b >> sh;
         13:     return sra_f(b, sh);
         14:     return b << a[4:0];
         15:     return b >> a[4:0];
         16:     return sra_f(b, a[4:0]);
         17, 18: return a + se;
         19:     return a & {16'h0, imm};
         20:     return a | {16'h0, imm};
         21:     return a ^ {16'h0, imm};
         22:     return {imm, 16'h0};
         23:     return (int'(a) < int'(se)) ? 32'd1 : 32'd0;
         24:     return (a < se) ? 32'd1 : 32'd0;
         25:     return pc + 32'd8;
         26:     return m_hi;
         27:     return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [15:0] imm);
      longint s;
      case (op)
         1:       s = longint'(int'(a)) + longint'(int'(b));
         3:       s = longint'(int'(a)) - longint'(int'(b));
         17:      s = longint'(int'(a)) + longint'(int'(sext(imm)));
         default: s = 0;
      endcase
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Drive one combinational vector and compare every combinational output
   task automatic apply_comb(input string tag, input logic [4:0] op, input logic [3:0] memop,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [31:0] pc);
      logic [31:0] ea, exp_c, exp_sd;
      logic [1:0]  lo2;
      logic        is_mem, exp_le, exp_lerr, exp_serr;
      logic [3:0]  exp_be;
      bus.Op = op; bus.MemOp = memop; bus.A = a; bus.B = b;
      bus.Shamt = sh; bus.Imm16 = imm; bus.PC = pc;
      #1;
      ea       = a + sext(imm);
      lo2      = ea[1:0];
      is_mem   = (memop >= 1) && (memop <= 8);
      exp_c    = is_mem ? ea : ref_alu(op, a, b, sh, imm, pc);
      exp_le   = (memop >= 1) && (memop <= 5);
      exp_lerr = (memop == 3 || memop == 4) ? (ea % 2 != 0) : (memop == 5) ? (ea % 4 != 0) : 1'b0;
      exp_serr = (memop == 7) ? (ea % 2 != 0) : (memop == 8) ? (ea % 4 != 0) : 1'b0;
      case (memop)
         6:       exp_be = 4'b0001 << lo2;
         7:       exp_be = exp_serr ? 4'b0000 : ((ea % 4 >= 2) ? 4'b1100 : 4'b0011);
         8:       exp_be = exp_serr ? 4'b0000 : 4'b1111;
         default: exp_be = 4'b0000;
      endcase
      case (memop)
         6:       exp_sd = {4{b[7:0]}};
         7:       exp_sd = {2{b[15:0]}};
         default: exp_sd = b;
      endcase
      check({tag, ".C"}, bus.C, exp_c);
      check({tag, ".ovf"}, bus.OverFlow, ref_ovf(op, a, b, imm));
      check({tag, ".memctl"}, {bus.LoadEn, bus.LoadAlignErr, bus.StoreAlignErr, bus.ByteEn},
            {exp_le, exp_lerr, exp_serr, exp_be});
      check({tag, ".sdata"}, bus.StoreData, exp_sd);
   endtask

   task automatic ref_muldiv(input logic [2:0] x, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      longint sa, sb;
      hi = m_hi; lo = m_lo;
      case (x)
         1: begin p = longint'(int'(a)) * longint'(int'(b)); hi = p[63:32]; lo = p[31:0]; end
         2: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
         3, 4: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF; hi = a;
            end else if (x == 3) begin
               sa = longint'(int'(a)); sb = longint'(int'(b));
               lo = 32'(sa / sb); hi = 32'(sa % sb);
            end else begin
               lo = a / b; hi = a % b;
            end
         end
         default: ;
      endcase
   endtask

   // Launch one multiply/divide, hammer XOp while busy, then check result
   task automatic run_muldiv(input string tag, input logic [2:0] x, input logic [31:0] a,
                             input logic [31:0] b);
      logic [31:0] eh, el;
      int n;
      ref_muldiv(x, a, b, eh, el);
      n = (x <= 2) ? MUL_N : DIV_N;
      bus.XOp = x; bus.A = a; bus.B = b;
      @(posedge Clk); #1;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.busy%0d", tag, i), bus.Busy, MD);
         bus.XOp = 3'($urandom_range(1, 6)); bus.A = $urandom; bus.B = $urandom;
         @(posedge Clk); #1;
      end
      bus.XOp = 3'd0;
      if (MD) begin m_hi = eh; m_lo = el; end
      check({tag, ".busy_end"}, bus.Busy, 1'b0);
      check({tag, ".HI"}, bus.HI, m_hi);
      check({tag, ".LO"}, bus.LO, m_lo);
   endtask

   task automatic move_to(input logic [2:0] x, input logic [31:0] v);
      bus.XOp = x; bus.A = v;
      @(posedge Clk); #1;
      bus.XOp = 3'd0;
      if (MD && x == 5) m_hi = v;
      if (MD && x == 6) m_lo = v;
      check(x == 5 ? "mthi" : "mtlo", x == 5 ? bus.HI : bus.LO, x == 5 ? m_hi : m_lo);
   endtask

   initial begin
      logic [2:0] x;
      logic [31:0] a, b;
      bus.Op = '0; bus.MemOp = '0; bus.XOp = '0; bus.A = '0; bus.B = '0;
      bus.Shamt = '0; bus.Imm16 = '0; bus.PC = '0; bus.Flush = 1'b0;
      Clr = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst.HI", bus.HI, 32'h0);
      check("rst.LO", bus.LO, 32'h0);
      check("rst.Busy", bus.Busy, 1'b0);
      Clr = 1'b1;

      // Directed ALU / memory corner cases
      apply_comb("add_ovf", 5'd1, 4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 16'h0, 32'h0);
      check("add_ovf.lit", {bus.OverFlow, bus.C}, {1'b1, 32'h8000_0000});
      apply_comb("addu", 5'd2, 4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 16'h0, 32'h0);
      check("addu.lit", bus.OverFlow, 1'b0);
      apply_comb("sra", 5'd13, 4'd0, 32'h0, 32'hF000_0000, 5'd4, 16'h0, 32'h0);
      check("sra.lit", bus.C, 32'hFF00_0000);
      apply_comb("sltiu", 5'd24, 4'd0, 32'd5, 32'h0, 5'd0, 16'hFFFF, 32'h0);
      check("sltiu.lit", bus.C, 32'd1);
      apply_comb("sh", 5'd0, 4'd7, 32'h1001, 32'hABCD_1234, 5'd0, 16'h1, 32'h0);
      check("sh.lit", {bus.C, bus.ByteEn}, {32'h1002, 4'b1100});
      apply_comb("lw_mis", 5'd0, 4'd5, 32'h1000, 32'h0, 5'd0, 16'h2, 32'h0);
      check("lw_mis.lit", bus.LoadAlignErr, 1'b1);
      apply_comb("link", 5'd25, 4'd0, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0040_0100);

      // Directed multiply/divide
      run_muldiv("mult", 3'd1, 32'hFFFF_FFFD, 32'd7);
      check("mult.lit", {bus.HI, bus.LO}, MD ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0);
      run_muldiv("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
      check("div.lit", {bus.HI, bus.LO}, MD ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0);
      run_muldiv("divu0", 3'd4, 32'h1234_5678, 32'd0);
      run_muldiv("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_muldiv("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      move_to(3'd5, 32'hCAFE_0001);
      move_to(3'd6, 32'hBEEF_0002);
      apply_comb("mfhi", 5'd26, 4'd0, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0);
      apply_comb("mflo", 5'd27, 4'd0, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0);

      // Random combinational traffic
      for (int i = 0; i < 300; i++) begin
         apply_comb($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                    rnd32(), rnd32(), 5'($urandom), 16'($urandom), $urandom);
      end

      // Random multiply/divide traffic
      for (int i = 0; i < 14; i++) begin
         x = 3'($urandom_range(1, 4));
         a = rnd32();
         b = ($urandom_range(0, 4) == 0) ? 32'h0 : rnd32();
         run_muldiv($sformatf("mdrnd%0d", i), x, a, b);
      end

      // Flush in the middle of a divide: result dropped, HI/LO untouched
      bus.XOp = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
      @(posedge Clk); #1;
      bus.XOp = 3'd0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("flush.busy%0d", i), bus.Busy, MD);
         @(posedge Clk); #1;
      end
      bus.Flush = 1'b1;
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      check("flush.busy_after", bus.Busy, 1'b0);
      check("flush.HI", bus.HI, m_hi);
      check("flush.LO", bus.LO, m_lo);
      repeat (40) @(posedge Clk);
      #1;
      check("flush.HI_late", bus.HI, m_hi);
      check("flush.LO_late", bus.LO, m_lo);

      // Flush blocks acceptance in the same cycle
      bus.XOp = 3'd1; bus.A = 32'd3; bus.B = 32'd3; bus.Flush = 1'b1;
      @(posedge Clk); #1;
      bus.XOp = 3'd0; bus.Flush = 1'b0;
      check("flush_acc.busy", bus.Busy, 1'b0);
      repeat (6) @(posedge Clk);
      #1;
      check("flush_acc.LO", bus.LO, m_lo);

      // Reset clears HI/LO
      move_to(3'd5, 32'h0000_1234);
      Clr = 1'b0;
      @(posedge Clk); #1;
      Clr = 1'b1;
      m_hi = '0; m_lo = '0;
      check("clr.HI", bus.HI, 32'h0);
      check("clr.LO", bus.LO, 32'h0);
      check("clr.Busy", bus.Busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute-stage arithmetic core of the 5-stage MIPS pipeline, placed between the decode/forwarding muxes and the execute pipeline register.
- Three functions:
  - Combinational integer ALU with overflow detection.
  - Combinational load/store control: address, byte enables, store data, alignment check.
  - Sequential multiply/divide unit with HI/LO registers and a busy flag.

Parameters:
- MUL_CYCLES, 4: cycles Busy stays high for MULT/MULTU.
- DIV_CYCLES, 32: cycles Busy stays high for DIV/DIVU.

Ports:
- Clk in 1: clock, rising edge.
- Clr in 1: reset. Synchronous, active-low.
- Op in 5: ALU operation code, encoding listed under Behaviour.
- MemOp in 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Values 9-15 are treated as none.
- XOp in 3: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Value 7 is treated as none.
- A in 32: forwarded rs operand.
- B in 32: forwarded rt operand.
- Shamt in 5: shift amount.
- Imm16 in 16: instruction immediate.
- PC in 32: instruction address.
- Flush in 1: exception/flush request; cancels an in-flight multiply/divide.
- C out 32: ALU result, or effective address for memory ops.
- OverFlow out 1: signed overflow of ADD/SUB/ADDI.
- LoadEn out 1: high for MemOp 1-5.
- ByteEn out 4: store byte enables.
- StoreData out 32: lane-replicated store data.
- LoadAlignErr out 1: misaligned load.
- StoreAlignErr out 1: misaligned store.
- HI out 32: HI register.
- LO out 32: LO register.
- Busy out 1: multiply/divide in progress.

Behaviour:
- C, OverFlow and all memory-control outputs are purely combinational.
- Immediates: sext = sign-extended Imm16; zext = zero-extended Imm16.
- Op encoding (result on C):
  - 0 NOP: 0
  - 1 ADD, 2 ADDU: A+B
  - 3 SUB, 4 SUBU: A-B
  - 5 AND, 6 OR, 7 XOR: bitwise A op B
  - 8 NOR: ~(A|B)
  - 9 SLT: signed A<B ? 1 : 0
  - 10 SLTU: unsigned A<B ? 1 : 0
  - 11 SLL, 12 SRL, 13 SRA: B shifted by Shamt
  - 14 SLLV, 15 SRLV, 16 SRAV: B shifted by A[4:0]
  - 17 ADDI, 18 ADDIU: A+sext
  - 19 ANDI, 20 ORI, 21 XORI: A op zext
  - 22 LUI: {Imm16,16'h0}
  - 23 SLTI: signed A<sext
  - 24 SLTIU: unsigned A<sext
  - 25 LINK: PC+8
  - 26 MFHI: HI
  - 27 MFLO: LO
  - 28-31: 0
- OverFlow is 1 only for Op 1, 3 and 17, when the signed 33-bit result's bit 32 differs from bit 31. Otherwise 0. C still carries the wrapped sum.
- Memory ops: when MemOp is in 1-8, C = A+sext, overriding Op. Below, addr = C[1:0].
- Alignment errors:
  - LH/LHU/SH: error when addr[0]=1.
  - LW/SW: error when addr≠0.
  - Byte ops never error.
  - The error goes to LoadAlignErr or StoreAlignErr according to the op.
- Store byte enables:
  - SB: 1<<addr.
  - SH: addr[1] ? 4'b1100 : 4'b0011.
  - SW: 4'b1111.
  - Forced to 0 on StoreAlignErr or for non-store ops.
- StoreData: SB = {4{B[7:0]}}, SH = {2{B[15:0]}}, otherwise B.
- Multiply/divide sequencing:
  - An op is accepted when XOp is 1-4 and Busy=0. Operands are latched at acceptance.
  - Busy rises on the next edge and stays high exactly MUL_CYCLES or DIV_CYCLES cycles.
  - On the edge where Busy falls, HI/LO load the result.
  - XOp values arriving while Busy=1 are ignored.
- MULT/MULTU: {HI,LO} = signed/unsigned 64-bit product.
- DIV/DIVU:
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = A.
  - 32'h80000000 / -1: LO = 32'h80000000, HI = 0.
- MTHI/MTLO: HI (or LO) = A on the next edge, only when Busy=0.
- Flush=1 at an edge:
  - Clears Busy and the counter.
  - Drops any pending result; HI/LO keep their old values.
  - Blocks acceptance of a new op in that cycle.
- Clr=0 at an edge: HI=0, LO=0, Busy=0, counter=0. Clr has priority over Flush.

Optional Feature:
- EXEC_MULDIV_EN:
  - Defined: the multiply/divide unit is built as described above.
  - Undefined:
    - XOp is ignored.
    - HI=LO=0 and Busy=0 constantly.
    - MFHI and MFLO return 0.
    - No sequential logic remains apart from nothing.

Test Plan:
- ADD A=32'h7FFFFFFF, B=1 -> C=32'h80000000, OverFlow=1. ADDU with the same operands -> OverFlow=0.
- SRA B=32'hF0000000, Shamt=4 -> C=32'hFF000000. SLTIU A=5, Imm16=16'hFFFF -> C=1.
- SH, A=32'h1001, Imm16=1 -> C=32'h1002, ByteEn=4'b1100, StoreData={2{B[15:0]}}. LW with address 32'h1002 -> LoadAlignErr=1.
- MULT A=-3, B=7 -> Busy high 4 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV A=-7, B=2 -> after 32 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU by 0 -> LO=32'hFFFFFFFF, HI=A.
- Start DIV, assert Flush at cycle 10 -> Busy=0 the next cycle, HI/LO unchanged. Clr=0 -> HI=LO=0.
